imem_loader: RTL and testbench

- Sequences writes into the 256 x 32-bit instruction memory from a byte-wide valid/ready stream (UART or debug bridge side).
- Assembles little-endian bytes into words and writes them to consecutive word addresses starting at 0.
- Holds the core in reset for the whole load.
- Owns the memory address mux: the fetch PC drives the memory when idle, the loader drives it while loading.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_byte_packer.sv | 62 ++++++
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: geometry of the
// 256 x 32-bit instruction memory and the loader FSM state encoding.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;
    localparam int IMEM_BPW    = IMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready) plus instruction-memory port bundle.
// "master" is the environment side (byte source, core PC, memory);
// "slave" is the loader.
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) ();

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] imem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        output fetch_addr,
        input  in_ready,
        input  imem_a,
        input  mem_we,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  fetch_addr,
        output in_ready,
        output imem_a,
        output mem_we,
        output mem_wdata
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Little-endian byte-to-word assembler. Byte k of a word lands in bits
// [8k+7:8k]. The "word" output already includes the byte being accepted
// this cycle, so the caller can capture a complete word on the same edge
// that accepts its last byte.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_complete,
    output logic [DATA_W-1:0] word
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [CNT_W-1:0]  byte_cnt_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;

    // Each byte lane takes the incoming byte only when the counter points at it.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        assign word[8*gi +: 8] = (byte_valid && (byte_cnt_reg == CNT_W'(gi)))
                                 ? byte_data : shift_reg[8*gi +: 8];
    end

    assign word_complete = byte_valid && (byte_cnt_reg == CNT_W'(BPW - 1));

    // Next counter/lane contents: clear drops any partial word.
    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        if (clear) begin
            byte_cnt_next = '0;
            shift_next    = '0;
        end else if (word_complete) begin
            byte_cnt_next = '0;
            shift_next    = '0;
        end else if (byte_valid) begin
            byte_cnt_next = byte_cnt_reg + CNT_W'(1);
            shift_next    = word;
        end
    end

    // Counter and partial-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
            shift_reg    <= '0;
        end else begin
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream, packs it into words and
// writes them to consecutive addresses from 0 while holding the core in
// reset. When idle, the core PC owns the memory address.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [ADDR_W:0] len,
    input  logic          abort,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    imem_loader_if.slave  bus
);

    // Largest legal word count (full memory depth), sized like len.
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] word_addr_reg;
    logic [ADDR_W-1:0] word_addr_next;
    logic [ADDR_W:0]   words_left_reg;
    logic [ADDR_W:0]   words_left_next;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] wdata_next;
    logic              err_reg;
    logic              err_next;

    logic              xfer;
    logic              word_complete;
    logic [DATA_W-1:0] packed_word;
    logic              len_ok;
    logic              last_word;

    assign len_ok    = (len != '0) && (len <= DEPTH_L);
    assign last_word = (words_left_reg == (ADDR_W+1)'(1));

    assign bus.in_ready  = (state_reg == LOAD);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign busy          = (state_reg == LOAD) || (state_reg == WRITE);
    assign cpu_hold      = busy;
    assign done          = (state_reg == DONE);
    assign err           = err_reg;
    assign bus.mem_we    = (state_reg == WRITE);
    assign bus.mem_wdata = wdata_reg;
    assign bus.imem_a    = busy ? word_addr_reg : bus.fetch_addr;

    // Packer is held clear while idle so every load starts on byte 0.
    imem_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (state_reg == IDLE),
        .byte_valid    (xfer),
        .byte_data     (bus.in_data),
        .word_complete (word_complete),
        .word          (packed_word)
    );

    // Next-state and datapath updates; abort takes priority over start.
    always_comb begin
        state_next      = state_reg;
        word_addr_next  = word_addr_reg;
        words_left_next = words_left_reg;
        wdata_next      = wdata_reg;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        state_next      = LOAD;
                        words_left_next = len;
                        word_addr_next  = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    if (start) begin
                        err_next = 1'b1;
                    end
                    if (word_complete) begin
                        wdata_next = packed_word;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                // The write itself happens this cycle regardless of abort.
                words_left_next = words_left_reg - (ADDR_W+1)'(1);
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    state_next     = LOAD;
                    word_addr_next = word_addr_reg + ADDR_W'(1);
                end
                if (start) begin
                    err_next = 1'b1;
                end
                if (abort) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (start) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The address counter never carries over past the end of a load.
        if (state_next == IDLE) begin
            word_addr_next = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            word_addr_reg  <= '0;
            words_left_reg <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_addr_reg  <= word_addr_next;
            words_left_reg <= words_left_next;
            wdata_reg      <= wdata_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader. The reference model is simply the byte
// list: word i of a load is bytes 4i..4i+3 little-endian and must be written
// to address i, exactly once, in order.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] len = '0;
    logic       abort = 1'b0;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    byte unsigned stim[$];
    logic [7:0]   obs_a[$];
    logic [31:0]  obs_d[$];
    logic [7:0]   fetch;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
    endtask

    // Write monitor plus invariants that hold for every write / done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we) begin
                obs_a.push_back(bus.imem_a);
                obs_d.push_back(bus.mem_wdata);
                check_eq("in_ready_low_in_write", bus.in_ready, 1'b0);
                check_eq("hold_in_write", cpu_hold, 1'b1);
            end
            if (done) begin
                done_cnt++;
                check_eq("hold_released_at_done", cpu_hold, 1'b0);
            end
            if (err) err_cnt++;
        end
    end

    // gap_mode: 0 valid always high, 1 random, 2 repeating 1-0-0-1.
    // abort_at: bytes accepted before abort (-1 = none); dup_at: byte index
    // at which a second start is issued (-1 = none).
    task automatic do_load(input string name, input int nw, input int gap_mode,
                           input int abort_at, input int dup_at);
        int idx = 0;
        int budget = 0;
        int pi = 0;
        int nbytes = nw * 4;
        int exp_words;
        int exp_err;
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit dup_done = 1'b0;
        bit seen_done = 1'b0;
        logic [3:0] pat = 4'b1001;
        logic [31:0] exp_w;
        obs_a.delete();
        obs_d.delete();
        bus.fetch_addr = fetch;

        @(posedge clk); #1;
        start = 1'b1;
        len = nw[8:0];
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({name, "_hold_after_start"}, cpu_hold, 1'b1);

        while (idx < nbytes && budget < 20000 && !(abort_at >= 0 && idx >= abort_at)) begin
            case (gap_mode)
                0: bus.in_valid = 1'b1;
                1: bus.in_valid = 1'($urandom_range(0, 1));
                default: begin
                    bus.in_valid = pat[pi % 4];
                    pi++;
                end
            endcase
            bus.in_data = stim[idx];
            if (dup_at == idx && !dup_done) begin
                start = 1'b1;
                len = 9'd3;
                dup_done = 1'b1;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
        end
        bus.in_valid = 1'b0;
        check_eq({name, "_feed_in_budget"}, budget < 20000, 1'b1);

        if (abort_at >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check_eq({name, "_abort_idle"}, busy, 1'b0);
            check_eq({name, "_abort_err"}, err, 1'b1);
            check_eq({name, "_abort_imem_a"}, bus.imem_a, fetch);
            exp_words = abort_at / 4;
        end else begin
            for (int c = 0; c < 50 && !seen_done; c++) begin
                @(posedge clk);
                if (done_cnt > d0) seen_done = 1'b1;
            end
            check_eq({name, "_done_seen"}, seen_done, 1'b1);
            exp_words = nw;
        end
        repeat (4) @(posedge clk);
        #1;

        exp_err = ((abort_at >= 0) ? 1 : 0) + ((dup_at >= 0) ? 1 : 0);
        check_eq({name, "_write_count"}, obs_a.size(), exp_words);
        for (int i = 0; i < exp_words && i < obs_a.size(); i++) begin
            exp_w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            check_eq({name, "_addr"}, obs_a[i], i);
            check_eq({name, "_data"}, obs_d[i], exp_w);
        end
        check_eq({name, "_done_count"}, done_cnt - d0, (abort_at >= 0) ? 0 : 1);
        check_eq({name, "_err_count"}, err_cnt - e0, exp_err);
        check_eq({name, "_idle_busy"}, busy, 1'b0);
        check_eq({name, "_idle_imem_a"}, bus.imem_a, fetch);
        $display("load %s: len=%0d gap=%0d abort_at=%0d writes=%0d", name, nw, gap_mode,
                 abort_at, obs_a.size());
    endtask

    task automatic illegal_start(input string name, input logic [8:0] l);
        int e0 = err_cnt;
        int w0 = obs_a.size();
        @(posedge clk); #1;
        start = 1'b1;
        len = l;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({name, "_err"}, err, 1'b1);
        check_eq({name, "_busy"}, busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_err_once"}, err_cnt - e0, 1);
        check_eq({name, "_no_write"}, obs_a.size(), w0);
        $display("illegal start %s: len=%0d", name, l);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nw;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        fetch = 8'h5A;
        bus.fetch_addr = fetch;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_hold", cpu_hold, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_we", bus.mem_we, 1'b0);
        check_eq("rst_ready", bus.in_ready, 1'b0);
        check_eq("rst_wdata", bus.mem_wdata, 32'h0);
        check_eq("rst_imem_a", bus.imem_a, fetch);
        rst_n = 1'b1;
        $display("reset released");

        // Basic two-word load
        stim.delete();
        push_word(32'h00A00093);
        push_word(32'h01400113);
        do_load("basic", 2, 0, -1, -1);
        if (obs_d.size() == 2) begin
            check_eq("basic_w0_const", obs_d[0], 32'h00A00093);
            check_eq("basic_w1_const", obs_d[1], 32'h01400113);
        end

        // Same bytes with 1-0-0-1 valid pattern
        do_load("gaps", 2, 2, -1, -1);

        // Illegal starts
        illegal_start("len0", 9'd0);
        illegal_start("len257", 9'(257 + $urandom_range(0, 200)));

        // Start during a load
        stim.delete();
        for (int i = 0; i < 3; i++) push_word($urandom);
        do_load("dup_start", 3, 1, -1, 5);

        // Full-depth load, word i = i, then a load proving address restarts at 0
        stim.delete();
        for (int i = 0; i < 256; i++) push_word(32'(i));
        do_load("full", 256, 0, -1, -1);
        if (obs_a.size() == 256) begin
            check_eq("full_last_addr", obs_a[255], 8'hFF);
            check_eq("full_last_data", obs_d[255], 32'h000000FF);
        end
        stim.delete();
        push_word($urandom);
        do_load("after_full", 1, 1, -1, -1);

        // Abort after 2 bytes of word 1, and abort coinciding with a WRITE
        fetch = 8'h12;
        stim.delete();
        for (int i = 0; i < 3; i++) push_word($urandom);
        do_load("abort_mid", 3, 0, 6, -1);
        stim.delete();
        for (int i = 0; i < 4; i++) push_word($urandom);
        do_load("abort_write", 4, 1, 8, -1);

        // Random loads
        for (int t = 0; t < 6; t++) begin
            fetch = 8'($urandom);
            nw = $urandom_range(1, 6);
            stim.delete();
            for (int i = 0; i < nw; i++) push_word($urandom);
            do_load("rand", nw, $urandom_range(0, 2), -1, -1);
        end

        // Reset mid-load: outputs return to reset values without a clock edge
        fetch = 8'h33;
        bus.fetch_addr = fetch;
        @(posedge clk); #1;
        start = 1'b1;
        len = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_hold", cpu_hold, 1'b0);
        check_eq("arst_we", bus.mem_we, 1'b0);
        check_eq("arst_wdata", bus.mem_wdata, 32'h0);
        check_eq("arst_ready", bus.in_ready, 1'b0);
        check_eq("arst_imem_a", bus.imem_a, fetch);
        check_eq("arst_err", err, 1'b0);
        check_eq("arst_done", done, 1'b0);
        $display("async reset mid-load applied");
        @(posedge clk); #1;
        rst_n = 1'b1;
        stim.delete();
        push_word(32'h00000013);
        do_load("post_reset", 1, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
